// File: rtl/irq_controller.sv
// irq_controller -- memory-mapped interrupt controller for the core's
// interrupts[] input. Raw request lines are synchronised, edge- or
// level-detected, latched as PENDING and masked onto a registered output.
//
// Register window (32 bytes at BASE_ADDR, dataadr[1:0] ignored):
//   0x00 PENDING  read / write-1-to-clear
//   0x04 MASK     read / write, 1 = enabled
//   0x08 EDGE_SEL read / write, 1 = rising edge, 0 = level
//   0x0C FORCE    write-only, 1 sets pending; reads 0
//   0x10-0x1C     reserved (0x10/0x14 hold edge counters with IRQ_COUNT_EN)
//
// Optional feature: define IRQ_COUNT_EN for per-line 8-bit saturating
// edge counters (lines 0-3 at 0x10, lines 4-7 at 0x14; any write clears).
//
// Ports:
//   ph1        clock, rising edge
//   reset      synchronous, active-low
//   irq_in     raw asynchronous request lines
//   memwrite   core store strobe
//   dataadr    core data address
//   writedata  core store data
//   readdata   register read data, 0 outside the window
//   sel        dataadr is inside the window
//   interrupts registered PENDING & MASK
module irq_controller #(
  parameter int unsigned NIRQ        = 8,
  parameter logic [31:0] BASE_ADDR   = 32'hFFFF0000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic            ph1,
  input  logic            reset,
  input  logic [NIRQ-1:0] irq_in,
  input  logic            memwrite,
  input  logic [31:0]     dataadr,
  input  logic [31:0]     writedata,
  output logic [31:0]     readdata,
  output logic            sel,
  output logic [NIRQ-1:0] interrupts
);

  logic [NIRQ-1:0] sync_q [SYNC_STAGES];
  logic [NIRQ-1:0] sync_d [SYNC_STAGES];
  logic [NIRQ-1:0] p_q, p_d;
  logic [2:0]      arm_q, arm_d;
  logic [NIRQ-1:0] pending_q, pending_d;
  logic [NIRQ-1:0] mask_q, mask_d;
  logic [NIRQ-1:0] edge_sel_q, edge_sel_d;
  logic [NIRQ-1:0] interrupts_q, interrupts_d;

  logic [2:0]      offset;
  logic            we;
  logic [NIRQ-1:0] wdata, s, set, w1c, force_bits;
  logic            armed;

`ifdef IRQ_COUNT_EN
  logic [7:0] cnt_q [NIRQ];
  logic [7:0] cnt_d [NIRQ];
`endif

  assign sel        = (dataadr[31:5] == BASE_ADDR[31:5]);
  assign offset     = dataadr[4:2];
  assign we         = memwrite & sel;
  assign wdata      = writedata[NIRQ-1:0];
  assign s          = sync_q[SYNC_STAGES-1];
  assign armed      = (arm_q == 3'd0);
  assign interrupts = interrupts_q;

  always_comb begin
    sync_d[0] = irq_in;
    for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
    p_d   = s;
    arm_d = (arm_q != 3'd0) ? arm_q - 3'd1 : arm_q;

    w1c        = (we && offset == 3'd0) ? wdata : '0;
    force_bits = (we && offset == 3'd3) ? wdata : '0;
    // Edge detection is held off until the synchroniser and previous-sample
    // flops have refilled, so lines high through reset raise nothing.
    set        = {NIRQ{armed}} & s & ~p_q & edge_sel_q;

    // Edge-mode lines latch; level-mode lines simply follow s (plus FORCE).
    pending_d  = (edge_sel_q & ((pending_q & ~w1c) | set))
               | (~edge_sel_q & s)
               | force_bits;
    mask_d     = (we && offset == 3'd1) ? wdata : mask_q;
    edge_sel_d = (we && offset == 3'd2) ? wdata : edge_sel_q;
    interrupts_d = pending_q & mask_q;

`ifdef IRQ_COUNT_EN
    for (int unsigned i = 0; i < NIRQ; i++) begin
      cnt_d[i] = cnt_q[i];
      if (we && offset == ((i < 4) ? 3'd4 : 3'd5))
        cnt_d[i] = '0;
      else if (set[i] && cnt_q[i] != 8'hFF)
        cnt_d[i] = cnt_q[i] + 8'd1;
    end
`endif
  end

  always_comb begin
    readdata = '0;
    if (sel) begin
      case (offset)
        3'd0:    readdata[NIRQ-1:0] = pending_q;
        3'd1:    readdata[NIRQ-1:0] = mask_q;
        3'd2:    readdata[NIRQ-1:0] = edge_sel_q;
        default: readdata = '0;
      endcase
`ifdef IRQ_COUNT_EN
      for (int unsigned i = 0; i < NIRQ; i++) begin
        if (i < 4 && offset == 3'd4) readdata[8*i +: 8] = cnt_q[i];
        if (i >= 4 && offset == 3'd5) readdata[8*(i-4) +: 8] = cnt_q[i];
      end
`endif
    end
  end

  always_ff @(posedge ph1) begin
    if (!reset) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      p_q          <= '0;
      arm_q        <= 3'(SYNC_STAGES + 1);
      pending_q    <= '0;
      mask_q       <= '0;
      edge_sel_q   <= '0;
      interrupts_q <= '0;
`ifdef IRQ_COUNT_EN
      for (int unsigned i = 0; i < NIRQ; i++) cnt_q[i] <= '0;
`endif
    end else begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= sync_d[i];
      p_q          <= p_d;
      arm_q        <= arm_d;
      pending_q    <= pending_d;
      mask_q       <= mask_d;
      edge_sel_q   <= edge_sel_d;
      interrupts_q <= interrupts_d;
`ifdef IRQ_COUNT_EN
      for (int unsigned i = 0; i < NIRQ; i++) cnt_q[i] <= cnt_d[i];
`endif
    end
  end

endmodule
